fifo_flex: RTL

Parametrised synchronous FIFO, the successor to the team's basic 8x32 FIFO, for the UART and IO datapaths.
- Supports any DEPTH, not only powers of two.
- Exposes occupancy count and programmable almost-full / almost-empty flags.
- Allows write-while-full when a read happens in the same cycle.
- Records sticky overflow/underflow errors.
- Compile-time option selects first-word-fall-through (FWFT) read mode.

---
 rtl/fifo_flex.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO: any DEPTH, count, almost flags, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered-read mode.
module fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     dout_q;
  logic                 ovf, udf;
  logic                 rd_acc, wr_acc, mem_we, mem_re;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full         = (cnt == CNT_WIDTH'(DEPTH));
  assign almost_full  = (cnt >= CNT_WIDTH'(AF_LEVEL));
  assign almost_empty = (cnt <= CNT_WIDTH'(AE_LEVEL));
  assign wr_acc       = wr_en & (~full | rd_acc);
  assign count        = cnt;
  assign dout         = dout_q;
  assign overflow     = ovf;
  assign underflow    = udf;

`ifdef FIFO_FWFT_EN
  logic out_valid, mem_empty, bypass;

  // dout holds the head word, so memory holds at most DEPTH-1 words and
  // equal pointers unambiguously mean the memory is empty.
  assign mem_empty = (wr_ptr == rd_ptr);
  assign empty     = ~out_valid;
  assign rd_acc    = rd_en & out_valid;
  assign bypass    = wr_acc & (~out_valid | (rd_acc & mem_empty));
  assign mem_we    = wr_acc & ~bypass;
  assign mem_re    = rd_acc & ~mem_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dout_q    <= '0;
    end else begin
      if (bypass) begin
        dout_q    <= din;
        out_valid <= 1'b1;
      end else if (mem_re) begin
        dout_q    <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign empty  = (cnt == '0);
  assign rd_acc = rd_en & ~empty;
  assign mem_we = wr_acc;
  assign mem_re = rd_acc;

  // Non-blocking read of the slot being overwritten returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dout_q <= '0;
    else if (mem_re) dout_q <= mem[rd_ptr];
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (mem_we) wr_ptr <= ptr_inc(wr_ptr);
      if (mem_re) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      cnt <= cnt + CNT_WIDTH'(1);
      else if (rd_acc && !wr_acc) cnt <= cnt - CNT_WIDTH'(1);
      if (wr_en && !wr_acc) ovf <= 1'b1;
      if (rd_en && !rd_acc) udf <= 1'b1;
    end
  end
endmodule
